anton_neopixel_frame_loader: RTL and testbench
==============================================

# anton_neopixel_frame_loader

Upstream feeder for the NeoPixel controller's bus slave. Accepts a stream of 24-bit RGB pixels over a valid/ready handshake and quantises each to the controller's 8-bit packed format. Writes the pixels into the controller's pixel buffer, then programs the max-count and control registers to start transmission. Polls the controller's run bit before touching the buffer, so a frame being shifted out is never torn.

## Interface
- PIXELS_MAX, 66: capacity of the controller's pixel buffer; must equal the controller's PIXELS_MAX.
- PIXELS_BITS, CLOG2(PIXELS_MAX): width of the pixel index.
- busClk  in  1  single clock, shared with the controller's bus side.
- busResetN  in  1  reset, asynchronous, active-low.
- streamData  in  24  pixel, R[23:16] G[15:8] B[7:0].
- streamValid  in  1  streamData valid.
- streamLast  in  1  marks the final pixel of a frame.
- streamReady  out  1  loader accepts a beat this cycle.
- cfgLoop  in  1  value copied into the controller's loop bit at commit.
- busAddr  out  14  controller address; bit13=0 selects the buffer, bit13=1 selects registers.
- busDataOut  out  8  write data to the controller's busDataIn.
- busWrite  out  1  one-cycle write strobe.
- busRead  out  1  one-cycle read strobe.
- busDataIn  in  8  controller's busDataOut; valid the cycle after busRead.
- busy  out  1  high in every state except IDLE.
- frameDone  out  1  one-cycle pulse after the control write is issued.
- overflow  out  1  one-cycle pulse when the frame exceeds PIXELS_MAX.

## Operation
- Pixel pack: byte = {B[7:6], G[7:5], R[7:5]}, i.e. [7:6] blue, [5:3] green, [2:0] red.
- States: IDLE, POLL_REQ, POLL_WAIT, FILL, DROP, WR_LO, WR_HI, WR_CTRL, DONE.
- IDLE: streamReady=0. Moves to POLL_REQ when streamValid=1; the beat is not consumed.
- POLL_REQ: issues busRead, busAddr=0x2002. Next state POLL_WAIT.
- POLL_WAIT: samples busDataIn[2] (run).
  - run=1: back to POLL_REQ. Polls repeat every 2 cycles with no timeout.
  - run=0: clear index and count, go to FILL.
- FILL: streamReady=1. Each handshake (valid & ready) issues a buffer write: busAddr={1'b0, zero-extended index}, busDataOut=packed byte.
  - After each write, index increments and count=index+1.
  - If streamLast: go to WR_LO.
  - Else if index==PIXELS_MAX-1: go to DROP.
  - streamValid low: stall; index and state hold.
- DROP: streamReady=1; beats are discarded. The first dropped beat pulses overflow. On a beat with streamLast, go to WR_LO.
  - Edge case: when last coincides exactly with beat PIXELS_MAX, FILL goes straight to WR_LO; there is no DROP and no overflow pulse.
- WR_LO: write 0x2000 = count[7:0].
- WR_HI: write 0x2001 = count[15:8].
- WR_CTRL: write 0x2002 = {3'b000, 32bit=0, cfgLoop, run=1, limit=1, init=0}. This is 0x06, or 0x0E when cfgLoop=1.
- DONE: pulse frameDone, then return to IDLE.
- Count arithmetic: count is 16 bits, zero-extended, range 1..PIXELS_MAX. A frame of zero length is impossible, because a beat is always required.
- busWrite and busRead are never high in the same cycle.

## Timing
- All outputs are registered; the one exception is streamReady, which decodes the current state.
- Reset values: streamReady, busAddr, busDataOut, busWrite, busRead, busy, frameDone, overflow all 0; state IDLE; index 0.
- Bus write timing: a beat accepted at edge k gives busWrite=1 with its address and data for exactly the cycle after edge k. Throughput is 1 pixel per cycle.
- Frame latency, valid seen in IDLE:
  - edge 1: POLL_REQ
  - edge 2: busRead high
  - edge 3: POLL_WAIT sample
  - streamReady rises in the next cycle; first busWrite is 1 cycle after the first accept.
- After the last accept: the three register writes occupy three consecutive cycles, and frameDone follows on the next cycle.
- cfgLoop is sampled in the WR_CTRL cycle.
- busResetN asserted in any state: all outputs clear immediately, without a clock. A partial frame is never committed (no WR_CTRL write).

## Test plan
- Reset: hold busResetN=0 with streamValid=1 -> all outputs 0, no bus strobes. Release -> POLL_REQ on the first edge.
- 3-pixel frame, run=0:
  - stimulus: 0xFF0000, 0x00FF00, 0x0000FF(last)
  - required writes: 0x0000=0x07, 0x0001=0x38, 0x0002=0xC0, 0x2000=0x03, 0x2001=0x00, 0x2002=0x06
  - then one frameDone pulse; overflow never pulses.
- Busy controller: busDataIn=0x04 for 3 polls, then 0x00 -> busRead every 2 cycles at 0x2002; streamReady stays 0 until after the fourth poll.
- Overflow, PIXELS_MAX=4, 6 beats, last on beat 6 -> 4 buffer writes (0x0000–0x0003), 2 beats dropped, one overflow pulse, 0x2000=0x04.
- Stalls and loop: cfgLoop=1, streamValid toggled every other cycle -> no duplicate or skipped addresses, 0x2002=0x0E.
- Async reset after 2 of 5 pixels -> outputs 0 without waiting for a clock, no register writes. The next frame re-polls and starts at address 0x0000.

Source files
------------

// File: rtl/anton_neopixel_frame_loader.sv
// anton_neopixel_frame_loader
// Loads one frame of 24-bit RGB pixels into the NeoPixel controller's pixel
// buffer as packed 8-bit values. It then programs the max-count and control
// registers to start transmission. Before touching the buffer it polls the
// controller's run bit, so a frame that is still being shifted out is never
// overwritten.

module anton_neopixel_frame_loader #(
    parameter int PIXELS_MAX  = 66,
    parameter int PIXELS_BITS = $clog2(PIXELS_MAX)
) (
    input  logic        busClk,
    input  logic        busResetN,
    input  logic [23:0] streamData,
    input  logic        streamValid,
    input  logic        streamLast,
    output logic        streamReady,
    input  logic        cfgLoop,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataOut,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataIn,
    output logic        busy,
    output logic        frameDone,
    output logic        overflow
);

    typedef enum logic [3:0] {
        IDLE,
        POLL_REQ,
        POLL_WAIT,
        FILL,
        DROP,
        WR_LO,
        WR_HI,
        WR_CTRL,
        DONE
    } state_t;

    // Controller register map (bit13 set selects the register space)
    localparam logic [13:0] ADDR_COUNT_LO = 14'h2000;
    localparam logic [13:0] ADDR_COUNT_HI = 14'h2001;
    localparam logic [13:0] ADDR_CTRL     = 14'h2002;

    localparam logic [PIXELS_BITS-1:0] LAST_INDEX = PIXELS_BITS'(PIXELS_MAX - 1);

    state_t                 state, state_nxt;
    logic [PIXELS_BITS-1:0] index, index_nxt;
    logic [15:0]            count, count_nxt;
    logic                   drop_seen, drop_seen_nxt;

    logic [13:0] addr_nxt;
    logic [7:0]  data_nxt;
    logic        write_nxt;
    logic        read_nxt;
    logic        busy_nxt;
    logic        frame_done_nxt;
    logic        overflow_nxt;

    logic        accept;
    logic [7:0]  packed_pixel;

    // The low-order colour bits and the other status bits are dropped on purpose.
    logic unused_bits;
    assign unused_bits = ^{streamData[20:16], streamData[12:8], streamData[5:0],
                           busDataIn[7:3], busDataIn[1:0]};

    // RGB888 to the controller's {B[7:6], G[7:5], R[7:5]} byte
    assign packed_pixel = {streamData[7:6], streamData[15:13], streamData[23:21]};

    // Ready is the only unregistered output: it decodes the current state
    assign streamReady = (state == FILL) || (state == DROP);
    assign accept      = streamValid && streamReady;

    // Next-state and next-output decode
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nxt      = state;
        index_nxt      = index;
        count_nxt      = count;
        drop_seen_nxt  = drop_seen;
        addr_nxt       = busAddr;
        data_nxt       = busDataOut;
        write_nxt      = 1'b0;
        read_nxt       = 1'b0;
        frame_done_nxt = 1'b0;
        overflow_nxt   = 1'b0;

        case (state)
            IDLE: begin
                // The waiting beat is left in place; it is consumed in FILL
                if (streamValid) begin
                    state_nxt = POLL_REQ;
                end
            end

            POLL_REQ: begin
                read_nxt  = 1'b1;
                addr_nxt  = ADDR_CTRL;
                state_nxt = POLL_WAIT;
            end

            POLL_WAIT: begin
                // The run bit set means the controller is still shifting; ask again
                if (busDataIn[2]) begin
                    state_nxt = POLL_REQ;
                end else begin
                    index_nxt     = '0;
                    count_nxt     = '0;
                    drop_seen_nxt = 1'b0;
                    state_nxt     = FILL;
                end
            end

            FILL: begin
                if (accept) begin
                    write_nxt = 1'b1;
                    addr_nxt  = {1'b0, 13'(index)};
                    data_nxt  = packed_pixel;
                    index_nxt = index + PIXELS_BITS'(1);
                    count_nxt = 16'(index) + 16'd1;
                    // Last on exactly the final slot commits without passing through DROP
                    if (streamLast) begin
                        state_nxt = WR_LO;
                    end else if (index == LAST_INDEX) begin
                        state_nxt = DROP;
                    end
                end
            end

            DROP: begin
                if (accept) begin
                    if (!drop_seen) begin
                        overflow_nxt  = 1'b1;
                        drop_seen_nxt = 1'b1;
                    end
                    if (streamLast) begin
                        state_nxt = WR_LO;
                    end
                end
            end

            WR_LO: begin
                write_nxt = 1'b1;
                addr_nxt  = ADDR_COUNT_LO;
                data_nxt  = count[7:0];
                state_nxt = WR_HI;
            end

            WR_HI: begin
                write_nxt = 1'b1;
                addr_nxt  = ADDR_COUNT_HI;
                data_nxt  = count[15:8];
                state_nxt = WR_CTRL;
            end

            WR_CTRL: begin
                // {unused[7:5], 32bit=0, loop, run=1, limit=1, init=0}
                write_nxt = 1'b1;
                addr_nxt  = ADDR_CTRL;
                data_nxt  = {3'b000, 1'b0, cfgLoop, 1'b1, 1'b1, 1'b0};
                state_nxt = DONE;
            end

            DONE: begin
                frame_done_nxt = 1'b1;
                state_nxt      = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State, frame bookkeeping and registered outputs
    always_ff @(posedge busClk or negedge busResetN) begin
        if (!busResetN) begin
            state      <= IDLE;
            index      <= '0;
            count      <= '0;
            drop_seen  <= 1'b0;
            busAddr    <= '0;
            busDataOut <= '0;
            busWrite   <= 1'b0;
            busRead    <= 1'b0;
            busy       <= 1'b0;
            frameDone  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values, which matches the flop hardware.
            state      <= state_nxt;
            index      <= index_nxt;
            count      <= count_nxt;
            drop_seen  <= drop_seen_nxt;
            busAddr    <= addr_nxt;
            busDataOut <= data_nxt;
            busWrite   <= write_nxt;
            busRead    <= read_nxt;
            busy       <= busy_nxt;
            frameDone  <= frame_done_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_anton_neopixel_frame_loader.sv
// tb_anton_neopixel_frame_loader
// Scoreboard bench: every expected bus write is queued when its beat is driven,
// and a negedge monitor pops and compares each write as it appears on the bus.

module tb_anton_neopixel_frame_loader;

    localparam int PMAX = 4;

    logic        busClk;
    logic        busResetN;
    logic [23:0] streamData;
    logic        streamValid;
    logic        streamLast;
    logic        streamReady;
    logic        cfgLoop;
    logic [13:0] busAddr;
    logic [7:0]  busDataOut;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataIn;
    logic        busy;
    logic        frameDone;
    logic        overflow;

    anton_neopixel_frame_loader #(
        .PIXELS_MAX (PMAX)
    ) dut (
        .busClk      (busClk),
        .busResetN   (busResetN),
        .streamData  (streamData),
        .streamValid (streamValid),
        .streamLast  (streamLast),
        .streamReady (streamReady),
        .cfgLoop     (cfgLoop),
        .busAddr     (busAddr),
        .busDataOut  (busDataOut),
        .busWrite    (busWrite),
        .busRead     (busRead),
        .busDataIn   (busDataIn),
        .busy        (busy),
        .frameDone   (frameDone),
        .overflow    (overflow)
    );

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    int          read_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          reads_seen = 0;
    int          busy_polls_left = 0;
    int          frame_done_cnt = 0;
    int          overflow_cnt = 0;
    logic [23:0] pix[8];

    // 10 ns clock
    initial busClk = 1'b0;
    always #5 busClk = ~busClk;

    always @(posedge busClk) cyc++;

    function automatic logic [7:0] pack(input logic [23:0] p);
        logic [7:0] r, g, b;
        r = p[23:16];
        g = p[15:8];
        b = p[7:0];
        return {b[7:6], g[7:5], r[7:5]};
    endfunction

    function automatic logic [27:0] all_outs();
        return {streamReady, busAddr, busDataOut, busWrite, busRead, busy, frameDone, overflow};
    endfunction

    // Bus monitor and controller model for the run-bit readback
    always @(negedge busClk) begin
        if (busWrite || busRead) begin
            checks++;
            if (busWrite && busRead) begin
                errors++;
                $display("FAIL strobe_overlap: busWrite=%b busRead=%b required not both 1", busWrite, busRead);
            end
        end
        if (busWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=0x%04h data=0x%02h required no write", busAddr, busDataOut);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (busAddr !== e.addr || busDataOut !== e.data) begin
                    errors++;
                    $display("FAIL bus_write: got 0x%04h=0x%02h required 0x%04h=0x%02h",
                             busAddr, busDataOut, e.addr, e.data);
                end
            end
        end
        if (busRead) begin
            checks++;
            if (busAddr !== 14'h2002) begin
                errors++;
                $display("FAIL poll_addr: got 0x%04h required 0x2002", busAddr);
            end
            reads_seen++;
            read_cyc.push_back(cyc);
            if (busy_polls_left > 0) begin
                busDataIn = 8'h04;
                busy_polls_left--;
            end else begin
                busDataIn = 8'h00;
            end
        end
        if (frameDone) frame_done_cnt++;
        if (overflow)  overflow_cnt++;
    end

    // Drive n beats from pix[]; abort_after>0 stops after that many accepts
    task automatic send_frame(input int n, input bit gaps, input int abort_after);
        int   sent   = 0;
        int   budget = 0;
        bit   skip   = 0;
        bit   aborted = 0;
        while (sent < n) begin
            @(negedge busClk);
            budget++;
            if (budget > 200) begin
                errors++;
                checks++;
                $display("FAIL frame_timeout: accepted %0d required %0d", sent, n);
                break;
            end
            if (abort_after > 0 && sent == abort_after) begin
                aborted = 1;
                break;
            end
            if (gaps && skip) begin
                streamValid = 1'b0;
                streamLast  = 1'b0;
                skip = 0;
                continue;
            end
            skip = 1;
            streamValid = 1'b1;
            streamData  = pix[sent];
            streamLast  = (sent == n - 1);
            if (streamReady) begin
                if (sent < PMAX) exp_q.push_back('{addr: 14'(sent), data: pack(pix[sent])});
                sent++;
            end
        end
        if (!aborted && sent == n) begin
            int cnt;
            cnt = (n < PMAX) ? n : PMAX;
            exp_q.push_back('{addr: 14'h2000, data: 8'(cnt)});
            exp_q.push_back('{addr: 14'h2001, data: 8'(cnt >> 8)});
            exp_q.push_back('{addr: 14'h2002, data: cfgLoop ? 8'h0E : 8'h06});
            @(negedge busClk);
        end
        streamValid = 1'b0;
        streamLast  = 1'b0;
    endtask

    // Wait for the commit to finish and confirm a single frameDone pulse
    task automatic wait_done(input string name, input int done_before);
        int k = 0;
        while (frame_done_cnt == done_before && k < 30) begin
            @(negedge busClk);
            k++;
        end
        checks++;
        if (frame_done_cnt == done_before) begin
            errors++;
            $display("FAIL %s_done_timeout: frameDone pulses %0d required 1", name, frame_done_cnt - done_before);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_done: busy=%b required 0", name, busy);
        end
        repeat (3) @(negedge busClk);
        checks++;
        if (frame_done_cnt - done_before !== 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d pulses required 1", name, frame_done_cnt - done_before);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes_missing: %0d outstanding required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        int d0;
        busResetN   = 1'b0;
        streamValid = 1'b1;
        streamData  = 24'h123456;
        streamLast  = 1'b1;
        repeat (3) begin
            @(negedge busClk);
            checks++;
            if (all_outs() !== 28'd0) begin
                errors++;
                $display("FAIL reset_outputs: got 0x%07h required 0x0000000", all_outs());
            end
        end
        busResetN = 1'b1;
        @(posedge busClk); #1;
        checks++;
        if (busy !== 1'b1 || busRead !== 1'b0 || streamReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge: busy=%b busRead=%b ready=%b required 1 0 0", busy, busRead, streamReady);
        end
        @(posedge busClk); #1;
        checks++;
        if (busRead !== 1'b1) begin
            errors++;
            $display("FAIL reset_second_edge_read: busRead=%b required 1", busRead);
        end
        d0 = frame_done_cnt;
        pix[0] = 24'h123456;
        send_frame(1, 0, 0);
        wait_done("reset", d0);
    endtask

    task automatic test_basic();
        int d0, o0;
        d0 = frame_done_cnt;
        o0 = overflow_cnt;
        pix[0] = 24'hFF0000;
        pix[1] = 24'h00FF00;
        pix[2] = 24'h0000FF;
        send_frame(3, 0, 0);
        wait_done("basic", d0);
        checks++;
        if (overflow_cnt != o0) begin
            errors++;
            $display("FAIL basic_overflow: got %0d pulses required 0", overflow_cnt - o0);
        end
    endtask

    task automatic test_busy_poll();
        int r0, q0, k, d0;
        bit bad_gap;
        d0 = frame_done_cnt;
        r0 = reads_seen;
        q0 = read_cyc.size();
        busy_polls_left = 3;
        pix[0] = 24'hA0B0C0;
        pix[1] = 24'h102030;
        @(negedge busClk);
        streamValid = 1'b1;
        streamData  = pix[0];
        streamLast  = 1'b0;
        k = 0;
        while (k < 40) begin
            @(posedge busClk); #1;
            k++;
            if (streamReady) break;
        end
        checks++;
        if (k != 9) begin
            errors++;
            $display("FAIL busy_ready_edge: ready after %0d edges required 9", k);
        end
        checks++;
        if (reads_seen - r0 != 4) begin
            errors++;
            $display("FAIL busy_poll_count: got %0d reads required 4", reads_seen - r0);
        end
        bad_gap = 0;
        for (int i = q0 + 1; i < read_cyc.size(); i++) begin
            if (read_cyc[i] - read_cyc[i-1] != 2) bad_gap = 1;
        end
        checks++;
        if (bad_gap) begin
            errors++;
            $display("FAIL busy_poll_spacing: read interval not 2 cycles required 2");
        end
        send_frame(2, 0, 0);
        wait_done("busy", d0);
    endtask

    task automatic test_overflow(input int n, input int exp_pulses, input string name);
        int d0, o0;
        d0 = frame_done_cnt;
        o0 = overflow_cnt;
        for (int i = 0; i < n; i++) pix[i] = 24'($urandom);
        send_frame(n, 0, 0);
        wait_done(name, d0);
        checks++;
        if (overflow_cnt - o0 != exp_pulses) begin
            errors++;
            $display("FAIL %s_overflow_pulses: got %0d required %0d", name, overflow_cnt - o0, exp_pulses);
        end
    endtask

    task automatic test_stall_loop();
        int d0;
        d0 = frame_done_cnt;
        cfgLoop = 1'b1;
        for (int i = 0; i < 4; i++) pix[i] = 24'($urandom);
        send_frame(4, 1, 0);
        wait_done("stall_loop", d0);
        cfgLoop = 1'b0;
    endtask

    task automatic test_async_reset();
        int d0;
        for (int i = 0; i < 5; i++) pix[i] = 24'($urandom);
        send_frame(5, 0, 2);
        #2;
        busResetN = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 28'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got 0x%07h required 0x0000000", all_outs());
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL async_reset_pixel_writes: %0d outstanding required 0", exp_q.size());
        end
        exp_q.delete();
        repeat (3) @(negedge busClk);
        busResetN = 1'b1;
        d0 = frame_done_cnt;
        for (int i = 0; i < 3; i++) pix[i] = 24'($urandom);
        send_frame(3, 0, 0);
        wait_done("after_reset", d0);
    endtask

    initial begin
        busResetN   = 1'b0;
        streamData  = '0;
        streamValid = 1'b0;
        streamLast  = 1'b0;
        cfgLoop     = 1'b0;
        busDataIn   = 8'h00;

        test_reset();
        test_basic();
        test_busy_poll();
        test_overflow(6, 1, "overflow");
        test_overflow(4, 0, "exact_fill");
        test_stall_loop();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if something hangs despite the bounded waits
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running required finish");
        $fatal(1);
    end

endmodule
